// File: rtl/baseline_ratio_detector.sv
// rtl/baseline_ratio_detector.sv - ratio-over-baseline event detector with onset/offset persistence
// Optional build macro: BASELINE_FREEZE_EN (hold the baseline while an event is active)
module baseline_ratio_detector #(
    parameter int FEAT_W      = 25,
    parameter int BASE_W      = 37,
    parameter int RATIO_SHIFT = 2,
    parameter int ONSET_CNT   = 5,
    parameter int OFFSET_CNT  = 10,
    parameter int CNT_W       = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic signed [FEAT_W-1:0] feat_in,
    input  logic                     feat_valid,
    input  logic        [BASE_W-1:0] base_in,
    input  logic                     base_valid,
    output logic                     base_locked,
    output logic                     detect,
    output logic                     onset_pulse,
    output logic                     offset_pulse
);

    localparam int CMP_W = (FEAT_W > BASE_W + RATIO_SHIFT) ? FEAT_W : BASE_W + RATIO_SHIFT;

    typedef enum logic [2:0] {
        WAIT_BASE,
        IDLE,
        ARMING,
        DETECT,
        RELEASING
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BASE_W-1:0]  base_reg_q, base_reg_d;
    logic               base_locked_q, base_locked_d;
    logic               detect_q, detect_d;
    logic               onset_q, onset_d;
    logic               offset_q, offset_d;

    logic [FEAT_W-1:0]  mag;
    logic [CMP_W-1:0]   mag_ext;
    logic [CMP_W-1:0]   thr;
    logic               above;
    logic               capture_ok;

    // Most-negative input has no positive twin, so it saturates to the largest magnitude.
    always_comb begin
        mag = feat_in;
        if (feat_in[FEAT_W-1]) begin
            if (feat_in == {1'b1, {(FEAT_W-1){1'b0}}}) begin
                mag = {1'b0, {(FEAT_W-1){1'b1}}};
            end else begin
                mag = -feat_in;
            end
        end
    end

    assign mag_ext = CMP_W'(mag);
    assign thr     = CMP_W'(base_reg_q) << RATIO_SHIFT;
    assign above   = mag_ext > thr;

`ifdef BASELINE_FREEZE_EN
    assign capture_ok = !detect_q;
`else
    assign capture_ok = 1'b1;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        base_reg_d    = base_reg_q;
        base_locked_d = base_locked_q;
        onset_d       = 1'b0;
        offset_d      = 1'b0;
        if (!en) begin
            if (base_valid && capture_ok) begin
                base_reg_d    = base_in;
                base_locked_d = 1'b1;
            end
            case (state_q)
                WAIT_BASE: begin
                    if (base_locked_d) state_d = IDLE;
                end
                IDLE: begin
                    if (feat_valid && above) begin
                        if (ONSET_CNT == 1) begin
                            state_d = DETECT;
                            cnt_d   = '0;
                            onset_d = 1'b1;
                        end else begin
                            state_d = ARMING;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                ARMING: begin
                    if (feat_valid) begin
                        if (!above) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else if (cnt_q + CNT_W'(1) == CNT_W'(ONSET_CNT)) begin
                            state_d = DETECT;
                            cnt_d   = '0;
                            onset_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                DETECT: begin
                    if (feat_valid && !above) begin
                        if (OFFSET_CNT == 1) begin
                            state_d  = IDLE;
                            cnt_d    = '0;
                            offset_d = 1'b1;
                        end else begin
                            state_d = RELEASING;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                RELEASING: begin
                    if (feat_valid) begin
                        if (above) begin
                            state_d = DETECT;
                            cnt_d   = '0;
                        end else if (cnt_q + CNT_W'(1) == CNT_W'(OFFSET_CNT)) begin
                            state_d  = IDLE;
                            cnt_d    = '0;
                            offset_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = WAIT_BASE;
                    cnt_d   = '0;
                end
            endcase
        end
        detect_d = (state_d == DETECT) || (state_d == RELEASING);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= WAIT_BASE;
            cnt_q         <= '0;
            base_reg_q    <= '0;
            base_locked_q <= 1'b0;
            detect_q      <= 1'b0;
            onset_q       <= 1'b0;
            offset_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            base_reg_q    <= base_reg_d;
            base_locked_q <= base_locked_d;
            detect_q      <= detect_d;
            onset_q       <= onset_d;
            offset_q      <= offset_d;
        end
    end

    assign base_locked  = base_locked_q;
    assign detect       = detect_q;
    assign onset_pulse  = onset_q;
    assign offset_pulse = offset_q;

endmodule

// File: tb/tb_baseline_ratio_detector.sv
// tb/tb_baseline_ratio_detector.sv - directed self-checking bench for baseline_ratio_detector
module tb_baseline_ratio_detector;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic signed [24:0] feat_in;
    logic               feat_valid;
    logic        [36:0] base_in;
    logic               base_valid;
    logic               base_locked;
    logic               detect;
    logic               onset_pulse;
    logic               offset_pulse;

    int n_checks = 0;
    int n_errors = 0;
    int n_on     = 0;
    int n_off    = 0;

    baseline_ratio_detector dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .feat_in      (feat_in),
        .feat_valid   (feat_valid),
        .base_in      (base_in),
        .base_valid   (base_valid),
        .base_locked  (base_locked),
        .detect       (detect),
        .onset_pulse  (onset_pulse),
        .offset_pulse (offset_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        n_on  += int'(onset_pulse);
        n_off += int'(offset_pulse);
    endtask

    task automatic feed(input logic signed [24:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            feat_in    = v;
            feat_valid = 1'b1;
            step();
        end
        feat_valid = 1'b0;
    endtask

    task automatic load_base(input logic [36:0] b);
        base_in    = b;
        base_valid = 1'b1;
        step();
        base_valid = 1'b0;
    endtask

    logic signed [24:0] patt [3];

    initial begin
        patt[0] = 25'sd401;
        patt[1] = -25'sd401;
        patt[2] = 25'h1000000;
        rst = 1'b0; en = 1'b0; feat_in = '0; feat_valid = 1'b0;
        base_in = '0; base_valid = 1'b0;
        step(); step();
        chk("rst_locked", base_locked, 0);
        chk("rst_detect", detect, 0);
        chk("rst_onset", onset_pulse, 0);
        rst = 1'b1;

        // 1: no baseline yet, features ignored
        n_on = 0; n_off = 0;
        feed(25'sd1000, 20);
        chk("t1_locked", base_locked, 0);
        chk("t1_detect", detect, 0);
        chk("t1_pulses", n_on + n_off, 0);

        // 2: strict compare and onset latency
        load_base(37'd100);
        chk("t2_locked", base_locked, 1);
        n_on = 0;
        feed(25'sd400, 5);
        chk("t2_eq_nodet", detect, 0);
        chk("t2_eq_noon", n_on, 0);
        feed(25'sd401, 4);
        chk("t2_4th_nodet", detect, 0);
        feed(25'sd401, 1);
        chk("t2_onset", onset_pulse, 1);
        chk("t2_detect", detect, 1);
        step();
        chk("t2_onset_1cyc", onset_pulse, 0);
        n_off = 0;
        feed(25'sd0, 10);
        chk("t2_release", n_off, 1);
        chk("t2_rel_det", detect, 0);

        // 3: interrupted run restarts the count; negative and saturated magnitudes
        for (int p = 0; p < 3; p++) begin
            n_on = 0;
            feed(patt[p], 4);
            feed(25'sd0, 1);
            feed(patt[p], 4);
            chk("t3_no_early", n_on, 0);
            feed(patt[p], 1);
            chk("t3_onset", onset_pulse, 1);
            chk("t3_one_onset", n_on, 1);
            if (p < 2) feed(25'sd0, 10);
        end

        // 4: release interrupted by an above sample
        n_off = 0;
        feed(25'sd0, 9);
        chk("t4_no_off9", n_off, 0);
        feed(25'sd500, 1);
        chk("t4_redetect", detect, 1);
        feed(25'sd0, 9);
        chk("t4_still_det", detect, 1);
        chk("t4_no_off", n_off, 0);
        feed(25'sd0, 1);
        chk("t4_offset", offset_pulse, 1);
        chk("t4_det_low", detect, 0);

        // baseline update during an event
        feed(25'sd401, 5);
        load_base(37'd1000);
        feed(25'sd0, 10);
        chk("t4f_det_low", detect, 0);
        feed(25'sd401, 5);
`ifdef BASELINE_FREEZE_EN
        chk("t4f_frozen", detect, 1);
`else
        chk("t4f_updated", detect, 0);
`endif
        feed(25'sd0, 10);
        load_base(37'd100);

        // 5: enable high freezes everything
        n_on = 0;
        feed(25'sd401, 2);
        en = 1'b1; feat_in = 25'sd401; feat_valid = 1'b1; base_in = 37'd5; base_valid = 1'b1;
        repeat (20) step();
        en = 1'b0; feat_valid = 1'b0; base_valid = 1'b0;
        chk("t5_frozen_det", detect, 0);
        chk("t5_frozen_on", n_on, 0);
        feed(25'sd401, 2);
        chk("t5_resume_nodet", detect, 0);
        feed(25'sd401, 1);
        chk("t5_resume_on", onset_pulse, 1);
        n_off = 0;
        feed(25'sd300, 10);
        chk("t5_base_held", n_off, 1);

        // 6: reset in the middle of an event
        feed(25'sd401, 5);
        chk("t6_pre_det", detect, 1);
        n_off = 0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("t6_det", detect, 0);
        chk("t6_locked", base_locked, 0);
        chk("t6_no_off", n_off, 0);
        n_on = 0;
        feed(25'sd1000, 10);
        chk("t6_ignored", n_on + int'(detect), 0);
        load_base(37'd100);
        feed(25'sd401, 5);
        chk("t6_relock_det", detect, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/baseline_ratio_detector.md
Name: baseline_ratio_detector

Overview:
- Consumer of the hierarchical sliding-window baseline. It takes the baseline value and its valid strobe, plus the per-sample feature stream (e.g. linelength).
- Flags an event when the feature magnitude exceeds 2^RATIO_SHIFT × baseline for ONSET_CNT consecutive samples.
- Releases the event after OFFSET_CNT consecutive samples at or below threshold.
- Sits downstream of the feature extractor and baseline block; feeds the event logger / stimulation controller.

Parameters:
FEAT_W, 25, feature sample width (signed)
BASE_W, 37, baseline width (unsigned)
RATIO_SHIFT, 2, threshold = baseline << RATIO_SHIFT (default 4x)
ONSET_CNT, 5, consecutive above-threshold samples to declare event (>=1)
OFFSET_CNT, 10, consecutive at/below-threshold samples to release event (>=1)
CNT_W, 8, persistence counter width (2^CNT_W > max(ONSET_CNT, OFFSET_CNT))

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-low
en  input  1  enable, active low; when high, all state frozen
feat_in  input  FEAT_W  signed feature sample
feat_valid  input  1  feat_in valid this cycle
base_in  input  BASE_W  baseline value
base_valid  input  1  base_in valid this cycle
base_locked  output  1  at least one baseline captured since reset
detect  output  1  event active (level)
onset_pulse  output  1  one-cycle pulse on event declaration
offset_pulse  output  1  one-cycle pulse on event release

Behaviour:
- Reset (rst=0 at posedge): base_reg=0, base_locked=0, detect=0, onset_pulse=0, offset_pulse=0, cnt=0, state=WAIT_BASE. A reset asserted mid-operation has the same effect; no pulse is emitted on the reset.
- All updates occur only when en=0. When en=1, all registers hold, inputs are ignored, and pulses are 0.
- Baseline capture: base_valid=1 → base_reg<=base_in, base_locked<=1.
- Simultaneous base_valid and feat_valid: the comparison uses the old base_reg. The new value applies from the next feature sample.
- Magnitude: mag = |feat_in|; the most-negative value saturates to 2^(FEAT_W-1)-1.
- Compare width CMP_W = max(FEAT_W, BASE_W+RATIO_SHIFT). Both operands are zero-extended to CMP_W, so the shift never truncates.
- above = mag > (base_reg << RATIO_SHIFT), strict comparison. A baseline of 0 means any nonzero sample is above.
- FSM, evaluated only on cycles with feat_valid=1; other cycles hold state:
  - WAIT_BASE: ignore features. Go to IDLE on the cycle base_locked becomes 1.
  - IDLE: above → cnt=1. If ONSET_CNT==1, go directly to DETECT with onset; otherwise go to ARMING.
  - ARMING: above → cnt++. When cnt+1==ONSET_CNT → DETECT, cnt=0, onset_pulse. !above → IDLE, cnt=0.
  - DETECT: !above → cnt=1. If OFFSET_CNT==1, go directly to IDLE with offset; otherwise go to RELEASING. above → stay.
  - RELEASING: !above → cnt++. When cnt+1==OFFSET_CNT → IDLE, cnt=0, offset_pulse. above → DETECT, cnt=0, no pulse.
- detect=1 in DETECT and RELEASING. All outputs are registered.
- Latency: onset_pulse/offset_pulse and the detect edge appear the cycle after the clock edge that samples the qualifying feat_valid.
- cnt never wraps, because the count condition always exits before overflow.

Optional Feature:
- Macro BASELINE_FREEZE_EN.
- Defined: while detect=1, base_valid is ignored (base_reg held), so event activity does not contaminate the baseline. Captures resume the cycle after detect falls.
- Undefined: base_reg updates on every base_valid regardless of state.

Test Plan:
1. Reset, no base_valid, feed 20 samples of feat=1000 → base_locked=0, detect=0, no pulses.
2. base_in=100; feed 5 samples of feat=400 → no detect (strict compare). Then 5 samples of feat=401 → onset_pulse one cycle after the 5th sample; detect=1.
3. base=100: 4 samples at 401, 1 at 0, then 5 at 401 → exactly one onset_pulse, after the 10th sample. Repeat with feat=-401 → identical. Repeat with feat=-2^24 → detects.
4. In DETECT: 9 samples at 0, 1 at 500, then 10 at 0 → no pulse during the first run; offset_pulse after the final 10th sample; detect=0.
   - With BASELINE_FREEZE_EN: base_valid with base_in=1000 during DETECT is ignored; the next event still triggers at 401.
5. base=100, in ARMING, en=1 for 20 cycles with feat_valid=1, feat=401 and base_valid=1, base_in=5 → no state, cnt, or base_reg change. Then en=0 → count resumes from the held value.
6. rst=0 for one cycle while in DETECT → detect=0, base_locked=0, no offset_pulse. Subsequent feat=1000 is ignored until the next base_valid.
